// File: rtl/spi_frame_arbiter.sv
// rtl/spi_frame_arbiter.sv - two-requester round-robin SPI frame master (option: SPI_FRAME_ARBITER_READBACK_EN)
module spi_frame_arbiter #(
   parameter int FRAME_BITS = 60,
   parameter int CLK_DIV    = 4,
   parameter int CSB_GAP    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                req_valid,
   input  logic [2*FRAME_BITS-1:0]   req_data,
   output logic [1:0]                req_ready,
   output logic                      busy,
   output logic                      done,
   output logic                      done_id,
   output logic [FRAME_BITS-1:0]     rd_data,
   output logic                      rd_valid,
   output logic                      SPI_CSB,
   output logic                      SPI_CLK,
   output logic                      SPI_SDI,
   input  logic                      SPI_SDO
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int DIV_W = 8;
   localparam int GAP_W = $clog2(CSB_GAP + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(CSB_GAP - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t                 state;
   logic [FRAME_BITS-1:0]  tx_shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic [DIV_W-1:0]       div_cnt;
   logic [GAP_W-1:0]       gap_cnt;
   logic                   owner;
   logic                   last_grant;
   logic                   win_id;
   logic [FRAME_BITS-1:0]  win_data;
   logic                   accept;
   logic                   div_end;

   // Round-robin pick: a lone requester wins, a tie goes to the one not granted last
   always_comb begin
      win_id = req_valid[1];
      if (req_valid == 2'b11) begin
         win_id = ~last_grant;
      end
   end

   assign win_data  = win_id ? req_data[2*FRAME_BITS-1:FRAME_BITS] : req_data[FRAME_BITS-1:0];
   assign req_ready = (state == IDLE && !reset) ? ({win_id, ~win_id} & req_valid) : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign div_end   = (div_cnt == DIV_END);

   // Frame sequencer: SETUP, one low/high SPI_CLK period per bit, HOLD, then CSB-high gap
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tx_shift   <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         gap_cnt    <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_id    <= 1'b0;
         SPI_CSB    <= 1'b1;
         SPI_CLK    <= 1'b0;
         SPI_SDI    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  tx_shift   <= win_data;
                  owner      <= win_id;
                  last_grant <= win_id;
                  bit_cnt    <= LAST_BIT;
                  div_cnt    <= '0;
                  busy       <= 1'b1;
                  SPI_CSB    <= 1'b0;
                  SPI_SDI    <= win_data[FRAME_BITS-1];
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (div_end) begin
                  div_cnt <= '0;
                  state   <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div_end) begin
                  div_cnt <= '0;
                  if (!SPI_CLK) begin
                     SPI_CLK <= 1'b1;
                  end else begin
                     SPI_CLK <= 1'b0;
                     if (bit_cnt == '0) begin
                        SPI_SDI <= 1'b0;
                        state   <= HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt - 1'b1;
                        tx_shift <= tx_shift << 1;
                        SPI_SDI  <= tx_shift[FRAME_BITS-2];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (div_end) begin
                  div_cnt <= '0;
                  gap_cnt <= '0;
                  SPI_CSB <= 1'b1;
                  done    <= 1'b1;
                  done_id <= owner;
                  state   <= GAP;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_END) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_FRAME_ARBITER_READBACK_EN
   logic [FRAME_BITS-1:0] rx_shift;

   // Capture SDO on every SPI_CLK rise and publish the word as CSB releases
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_shift <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (state == IDLE && accept) begin
            rx_shift <= '0;
         end else if (state == SHIFT && !SPI_CLK && div_end) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], SPI_SDO};
         end
         if (state == HOLD && div_end) begin
            rd_data  <= rx_shift;
            rd_valid <= 1'b1;
         end
      end
   end
`else
   logic sdo_unused;

   assign sdo_unused = SPI_SDO;
   assign rd_data    = '0;
   assign rd_valid   = 1'b0;
`endif

endmodule
